// File: rtl/wallace.sv
// 16x16 unsigned Wallace-tree multiplier with a single output register.
// Define APPROX_EN to replace the low APPROX_COLS columns with a per-column OR of their partial products.
module wallace #(
    parameter int APPROX_COLS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] sum
);

`ifdef APPROX_EN
    localparam bit APPROX_ON = 1'b1;
`else
    localparam bit APPROX_ON = 1'b0;
`endif

    localparam logic [63:0] COL_MASK64 = (64'd1 << APPROX_COLS) - 64'd1;
    localparam logic [31:0] LOW_MASK   = APPROX_ON ? COL_MASK64[31:0] : 32'd0;

    // Rows remaining after s layers of 3:2 compression, starting from 16 rows.
    function automatic int rows_at(input int s);
        int r;
        r = 16;
        for (int k = 0; k < s; k++) begin
            r = (r / 3) * 2 + (r % 3);
        end
        return r;
    endfunction

    localparam int NSTAGE = 6;

    logic [31:0] pp_row [0:15];
    logic [31:0] lvl    [0:NSTAGE][0:15];
    logic [31:0] col_or;
    logic [31:0] low_or;
    logic [31:0] exact_sum;
    logic [31:0] sum_d;
    logic [31:0] sum_q;

    genvar gi, gj;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_pp
            assign pp_row[gi] = {16'd0, a & {16{b[gi]}}} << gi;
            // Approximate columns are removed from the adder tree so no carry can leave them.
            assign lvl[0][gi] = pp_row[gi] & ~LOW_MASK;
        end

        for (gi = 0; gi < 32; gi++) begin : g_col
            logic [15:0] col_bits;
            for (gj = 0; gj < 16; gj++) begin : g_bit
                assign col_bits[gj] = pp_row[gj][gi];
            end
            assign col_or[gi] = |col_bits;
        end

        for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
            localparam int R_IN  = rows_at(gi);
            localparam int R_OUT = rows_at(gi + 1);
            localparam int NGRP  = R_IN / 3;
            for (gj = 0; gj < NGRP; gj++) begin : g_csa
                logic [31:0] x, y, z;
                assign x = lvl[gi][3*gj];
                assign y = lvl[gi][3*gj+1];
                assign z = lvl[gi][3*gj+2];
                assign lvl[gi+1][2*gj]   = x ^ y ^ z;
                // Carry out of bit 31 is dropped: the true total always fits in 32 bits.
                assign lvl[gi+1][2*gj+1] = {((x[30:0] & y[30:0]) | (x[30:0] & z[30:0]) | (y[30:0] & z[30:0])), 1'b0};
            end
            for (gj = 0; gj < R_IN % 3; gj++) begin : g_pass
                assign lvl[gi+1][2*NGRP+gj] = lvl[gi][3*NGRP+gj];
            end
            for (gj = R_OUT; gj < 16; gj++) begin : g_tie
                assign lvl[gi+1][gj] = 32'd0;
            end
        end
    endgenerate

    assign exact_sum = lvl[NSTAGE][0] + lvl[NSTAGE][1];
    assign low_or    = col_or & LOW_MASK;
    // Exact part has zeros below the approximate boundary, so OR merges the two disjoint fields.
    assign sum_d     = exact_sum | low_or;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_wallace.sv
// Scoreboard bench for wallace: expected products queued at drive time, compared one cycle later.
// Expected values follow the APPROX_EN setting of the build (default APPROX_COLS assumed).
module tb_wallace;

    localparam int K = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = 16'd0;
    logic [15:0] b   = 16'd0;
    logic [31:0] sum;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rst;
        logic [31:0] exp;
    } txn_t;

    txn_t sb_q[$];

    longint max_err = 0;

    wallace #(.APPROX_COLS(K)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sum (sum)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef APPROX_EN
        longint acc;
        acc = 0;
        for (int c = 0; c < 31; c++) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 16; i++) begin
                int j;
                j = c - i;
                if (j >= 0 && j < 16 && x[j] && y[i]) cnt++;
            end
            if (c < K) acc += (cnt != 0 ? 64'd1 : 64'd0) << c;
            else       acc += longint'(cnt) << c;
        end
        return acc[31:0];
`else
        return x * y;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [15:0] x, input logic [15:0] y, input logic r, input bit verbose);
        txn_t t;
        txn_t o;
        logic [31:0] exact;
        a   = x;
        b   = y;
        rst = r;
        t.a = x; t.b = y; t.rst = r;
        t.exp = r ? 32'd0 : model(x, y);
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        if (verbose)
            $display("%-10s a=0x%04h b=0x%04h rst=%0b sum=0x%08h exp=0x%08h", tag, o.a, o.b, o.rst, sum, o.exp);
        check(tag, sum, o.exp);
`ifdef APPROX_EN
        if (!o.rst) begin
            exact = o.a * o.b;
            check({tag, "_le"}, {31'd0, sum <= exact}, 32'd1);
            check({tag, "_bnd"}, {31'd0, (longint'(exact) - longint'(sum)) < (64'd1 << (K + 4))}, 32'd1);
            if (longint'(exact) - longint'(sum) > max_err) max_err = longint'(exact) - longint'(sum);
        end
`endif
    endtask

    initial begin
        // Reset held with all-ones operands, then released.
        drive("rst0", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drive("rst1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drive("max", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        drive("three", 16'd3, 16'd3, 1'b0, 1'b1);
        drive("single", 16'h0100, 16'h0100, 1'b0, 1'b1);
        drive("ones_x1", 16'hFFFF, 16'd1, 1'b0, 1'b1);
        drive("b2b_0", 16'd2, 16'd5, 1'b0, 1'b1);
        drive("b2b_1", 16'd7, 16'd9, 1'b0, 1'b1);
        drive("b2b_2", 16'd0, 16'h1234, 1'b0, 1'b1);
        drive("zero_b", 16'hBEEF, 16'd0, 1'b0, 1'b1);
        drive("pre_rst", 16'h00FF, 16'h00FF, 1'b0, 1'b1);
        drive("mid_rst", 16'h1234, 16'h5678, 1'b1, 1'b1);
        drive("post_rst", 16'h8000, 16'h8000, 1'b0, 1'b1);
        drive("a5a5", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            drive("rand", 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        end
`ifdef APPROX_EN
        $display("approx max_err=%0d", max_err);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
